// File: rtl/apb_slave_bank.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_bank
// Purpose  : APB slave model with NUM_SLV independent banks of DEPTH 32-bit
//            registers. The one-hot pselx selects the bank. Write data is
//            stored and returned on later reads. Wait states are
//            programmable, and an optional error response can be enabled.
//
// Ports    : hclk      - clock, rising edge
//            hreset    - synchronous active-high reset
//            pselx     - one-hot bank select [NUM_SLV]
//            penable   - APB access phase
//            pwrite    - 1 = write, 0 = read
//            paddr     - byte address, bits [1:0] ignored
//            pwdata    - write data
//            prdata    - read data; nonzero only with pready on a good read
//            pready    - one-cycle transfer-complete strobe
//            pslverr   - error response, qualified by pready
//            xfer_cnt  - completed transfer count, wraps
//
// Options  : `define APB_SLVERR_EN to drive pslverr on bad accesses.
//            Without it pslverr is tied low. Bad writes are dropped and bad
//            reads return 0 in both builds.
//
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_bank #(
    parameter int NUM_SLV     = 3,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [NUM_SLV-1:0] pselx,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic [15:0]        xfer_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_BW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [3:0] c_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_WAIT  = 2'd1;
    localparam logic [1:0] c_S_READY = 2'd2;

    logic [31:0]     r_mem [NUM_SLV][DEPTH];

    logic [1:0]      r_state;
    logic [3:0]      r_wcnt;
    logic [c_BW-1:0] r_bank;
    logic [c_AW-1:0] r_word;
    logic            r_write;
    logic [31:0]     r_wdata;
    logic            r_bad;
    logic [31:0]     r_prdata;
    logic            r_pready;
    logic [15:0]     r_xfer_cnt;
`ifdef APB_SLVERR_EN
    logic            r_err;
`endif

    logic [c_BW-1:0] w_bank;
    logic [c_AW-1:0] w_word;
    logic            w_sel_any;
    logic            w_multi;
    logic            w_bad;
    logic            w_setup;
    logic            w_go_ready;
    logic [c_BW-1:0] w_ent_bank;
    logic [c_AW-1:0] w_ent_word;
    logic            w_ent_write;
    logic            w_ent_bad;
    logic [31:0]     w_rd_data;
    logic            w_count;
    logic            w_commit;
    logic            w_unused;

    // Byte-lane bits carry no meaning for word-wide registers.
    assign w_unused = ^paddr[1:0];

    // Bank number from the select bus. A multi-bit select is flagged bad,
    // so the bank it picks here never reaches storage.
    always_comb begin
        w_bank = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (pselx[i]) begin
                w_bank = c_BW'(i);
            end
        end
    end

    assign w_word    = paddr[c_AW+1:2];
    assign w_sel_any = |pselx;
    assign w_multi   = |(pselx & (pselx - NUM_SLV'(1)));
    assign w_bad     = (|paddr[31:c_AW+2]) | w_multi;
    assign w_setup   = w_sel_any & ~penable;

    // READY is entered straight from IDLE when there are no wait states.
    // In that case the access fields come from the live bus, because the
    // captured copies are being loaded on the same edge.
    assign w_go_ready = ((r_state == c_S_IDLE) && w_setup && (WAIT_STATES == 0)) ||
                        ((r_state == c_S_WAIT) && w_sel_any && (r_wcnt == 4'd0));

    assign w_ent_bank  = (r_state == c_S_IDLE) ? w_bank : r_bank;
    assign w_ent_word  = (r_state == c_S_IDLE) ? w_word : r_word;
    assign w_ent_write = (r_state == c_S_IDLE) ? pwrite : r_write;
    assign w_ent_bad   = (r_state == c_S_IDLE) ? w_bad  : r_bad;
    assign w_rd_data   = r_mem[w_ent_bank][w_ent_word];

    // A transfer completes only if the master is still selecting this bank
    // and has raised penable in the READY cycle.
    assign w_count  = (r_state == c_S_READY) && w_sel_any && penable;
    assign w_commit = w_count && r_write && !r_bad;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int b = 0; b < NUM_SLV; b++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    r_mem[b][w] <= '0;
                end
            end
        end else if (w_commit) begin
            r_mem[r_bank][r_word] <= r_wdata;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state    <= c_S_IDLE;
            r_wcnt     <= 4'd0;
            r_bank     <= '0;
            r_word     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_bad      <= 1'b0;
            r_prdata   <= '0;
            r_pready   <= 1'b0;
            r_xfer_cnt <= 16'd0;
`ifdef APB_SLVERR_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_pready <= w_go_ready;
            r_prdata <= (w_go_ready && !w_ent_write && !w_ent_bad) ? w_rd_data : 32'd0;
`ifdef APB_SLVERR_EN
            r_err    <= w_go_ready & w_ent_bad;
`endif
            if (w_count) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (w_setup) begin
                        r_bank  <= w_bank;
                        r_word  <= w_word;
                        r_write <= pwrite;
                        r_wdata <= pwdata;
                        r_bad   <= w_bad;
                        if (WAIT_STATES > 0) begin
                            r_state <= c_S_WAIT;
                            r_wcnt  <= c_WS_LOAD;
                        end else begin
                            r_state <= c_S_READY;
                        end
                    end
                end
                c_S_WAIT: begin
                    // An abort takes priority over the final wait cycle.
                    if (!w_sel_any) begin
                        r_state <= c_S_IDLE;
                    end else if (r_wcnt == 4'd0) begin
                        r_state <= c_S_READY;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                c_S_READY: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign prdata   = r_prdata;
    assign pready   = r_pready;
    assign xfer_cnt = r_xfer_cnt;
`ifdef APB_SLVERR_EN
    assign pslverr  = r_err;
`else
    assign pslverr  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_bank
// Purpose  : Self-checking bench for apb_slave_bank. Three instances use
//            wait-state settings 0, 2 and 3, and each has its own APB bus.
//            A bench-side model of memory, counts and expected outputs is
//            compared against all instances every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_bank;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        hreset;
    logic [2:0]  psel [NDUT];
    logic        pen  [NDUT];
    logic        pwr  [NDUT];
    logic [31:0] pad  [NDUT];
    logic [31:0] pwd  [NDUT];
    logic [31:0] prd  [NDUT];
    logic        prdy [NDUT];
    logic        perr [NDUT];
    logic [15:0] cnt  [NDUT];

    // Model state
    logic [31:0] mem_m [NDUT][3][16];
    int          cnt_m [NDUT];
    logic        exp_rdy [NDUT];
    logic        exp_err [NDUT];
    logic [31:0] exp_rd  [NDUT];

    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_slave_bank #(
            .NUM_SLV    (3),
            .DEPTH      (16),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .hclk    (clk),
            .hreset  (hreset),
            .pselx   (psel[g]),
            .penable (pen[g]),
            .pwrite  (pwr[g]),
            .paddr   (pad[g]),
            .pwdata  (pwd[g]),
            .prdata  (prd[g]),
            .pready  (prdy[g]),
            .pslverr (perr[g]),
            .xfer_cnt(cnt[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h expected=%h t=%0t", name, d, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int d = 0; d < NDUT; d++) begin
            cnt_m[d]   = 0;
            exp_rdy[d] = 1'b0;
            exp_err[d] = 1'b0;
            exp_rd[d]  = 32'd0;
            for (int b = 0; b < 3; b++)
                for (int w = 0; w < 16; w++)
                    mem_m[d][b][w] = 32'd0;
        end
    endtask

    task automatic idle_bus(input int d);
        psel[d] = 3'b000;
        pen[d]  = 1'b0;
        pwr[d]  = 1'b0;
        pad[d]  = 32'd0;
        pwd[d]  = 32'd0;
    endtask

    // One complete APB transfer, entered and left at 1 time unit after a
    // rising edge. The setup phase is driven in the current cycle. On return
    // the bus is idle in the cycle right after READY, so the next call starts
    // back-to-back.
    task automatic apb(input int d, input logic [2:0] sel, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        int   ws;
        int   bank;
        int   word;
        logic bad;
        ws   = ws_of(d);
        bad  = (addr >= 32'd64) || ($countones(sel) != 1);
        word = int'((addr >> 2) % 16);
        bank = 0;
        for (int i = 0; i < 3; i++) if (sel[i]) bank = i;

        psel[d] = sel;
        pen[d]  = 1'b0;
        pwr[d]  = wr;
        pad[d]  = addr;
        pwd[d]  = wdata;
        for (int k = 1; k <= ws + 1; k++) begin
            tick();
            if (k == 1) begin
                pen[d] = 1'b1;
                // Bus changes after setup must not affect the transfer.
                pad[d] = ~addr;
                pwd[d] = ~wdata;
            end
            if (k == ws + 1) begin
                exp_rdy[d] = 1'b1;
`ifdef APB_SLVERR_EN
                exp_err[d] = bad;
`else
                exp_err[d] = 1'b0;
`endif
                exp_rd[d]  = (!wr && !bad) ? mem_m[d][bank][word] : 32'd0;
            end
        end
        @(negedge clk);
        rdata = prd[d];
        err   = perr[d];
        tick();
        idle_bus(d);
        exp_rdy[d] = 1'b0;
        exp_err[d] = 1'b0;
        exp_rd[d]  = 32'd0;
        cnt_m[d]++;
        if (wr && !bad) mem_m[d][bank][word] = wdata;
    endtask

    // The transfer is started, then pselx is dropped in cycle drop_k after
    // setup. The caller keeps drop_k within the wait window.
    task automatic apb_abort(input int d, input logic [2:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, input int drop_k);
        psel[d] = sel;
        pen[d]  = 1'b0;
        pwr[d]  = 1'b1;
        pad[d]  = addr;
        pwd[d]  = wdata;
        for (int k = 1; k <= drop_k; k++) begin
            tick();
            if (k == 1) pen[d] = 1'b1;
            if (k == drop_k) idle_bus(d);
        end
        tick();
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                chk("pready",   d, 32'(prdy[d]), 32'(exp_rdy[d]));
                chk("pslverr",  d, 32'(perr[d]), 32'(exp_err[d]));
                chk("prdata",   d, prd[d], exp_rd[d]);
                chk("xfer_cnt", d, 32'(cnt[d]), 32'(cnt_m[d] % 65536));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        exp_bad_err;
`ifdef APB_SLVERR_EN
        exp_bad_err = 1'b1;
`else
        exp_bad_err = 1'b0;
`endif
        hreset = 1'b1;
        for (int d = 0; d < NDUT; d++) idle_bus(d);
        reset_model();
        tick();
        tick();
        hreset = 1'b0;
        chk_en = 1'b1;
        chk("lit_reset_cnt", 0, 32'(cnt[0]), 32'd0);
        tick();

        // Basic write then read back, no wait states.
        apb(0, 3'b010, 32'h14, 1'b1, 32'hDEADBEEF, rd, er);
        apb(0, 3'b010, 32'h14, 1'b0, 32'h0, rd, er);
        chk("lit_rd_deadbeef", 0, rd, 32'hDEADBEEF);
        chk("lit_cnt_2", 0, 32'(cnt[0]), 32'd2);

        // Three wait states, read of a cleared word.
        apb(2, 3'b001, 32'h0, 1'b0, 32'h0, rd, er);
        chk("lit_ws3_rd0", 2, rd, 32'd0);

        // Independent banks at the same address.
        apb(0, 3'b001, 32'h8, 1'b1, 32'h11, rd, er);
        apb(0, 3'b100, 32'h8, 1'b1, 32'h22, rd, er);
        apb(0, 3'b001, 32'h8, 1'b0, 32'h0, rd, er);
        chk("lit_bank0", 0, rd, 32'h11);
        apb(0, 3'b100, 32'h8, 1'b0, 32'h0, rd, er);
        chk("lit_bank2", 0, rd, 32'h22);

        // Bad accesses: address out of range, then a multi-bit select.
        apb(0, 3'b001, 32'h40, 1'b1, 32'hBAD1, rd, er);
        chk("lit_err_addr", 0, 32'(er), 32'(exp_bad_err));
        apb(0, 3'b001, 32'h0, 1'b0, 32'h0, rd, er);
        chk("lit_bad_wr_dropped", 0, rd, 32'd0);
        apb(0, 3'b100, 32'h48, 1'b0, 32'h0, rd, er);
        chk("lit_bad_rd_zero", 0, rd, 32'd0);
        apb(0, 3'b011, 32'h8, 1'b1, 32'h99, rd, er);
        chk("lit_err_multi", 0, 32'(er), 32'(exp_bad_err));
        apb(0, 3'b011, 32'h14, 1'b0, 32'h0, rd, er);
        chk("lit_multi_rd_zero", 0, rd, 32'd0);
        apb(0, 3'b001, 32'h8, 1'b0, 32'h0, rd, er);
        chk("lit_multi_wr_dropped", 0, rd, 32'h11);

        // penable without a setup phase is ignored.
        psel[0] = 3'b010;
        pen[0]  = 1'b1;
        pwr[0]  = 1'b1;
        pwd[0]  = 32'hFFFF_FFFF;
        tick();
        idle_bus(0);
        tick();

        // Two wait states: normal transfer, then an abort mid-wait.
        apb(1, 3'b010, 32'hC, 1'b1, 32'h55, rd, er);
        apb(1, 3'b010, 32'hC, 1'b0, 32'h0, rd, er);
        chk("lit_ws2_rd", 1, rd, 32'h55);
        apb_abort(1, 3'b010, 32'hC, 32'h77, 2);
        chk("lit_abort_cnt", 1, 32'(cnt[1]), 32'd2);
        apb(1, 3'b010, 32'hC, 1'b0, 32'h0, rd, er);
        chk("lit_abort_nowrite", 1, rd, 32'h55);

        // Top word of a bank, then a reset during the wait of a write.
        apb(2, 3'b100, 32'h3C, 1'b1, 32'hCAFE, rd, er);
        apb(2, 3'b100, 32'h3C, 1'b0, 32'h0, rd, er);
        chk("lit_top_word", 2, rd, 32'hCAFE);
        psel[2] = 3'b100;
        pen[2]  = 1'b0;
        pwr[2]  = 1'b1;
        pad[2]  = 32'h3C;
        pwd[2]  = 32'h1234;
        tick();
        pen[2] = 1'b1;
        tick();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        idle_bus(2);
        reset_model();
        chk("lit_rst_cnt", 2, 32'(cnt[2]), 32'd0);
        tick();
        apb(2, 3'b100, 32'h3C, 1'b0, 32'h0, rd, er);
        chk("lit_rst_mem2", 2, rd, 32'd0);
        apb(0, 3'b010, 32'h14, 1'b0, 32'h0, rd, er);
        chk("lit_rst_mem0", 0, rd, 32'd0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
